range_dma_sequencer: RTL and testbench



---
 rtl/range_dma_sequencer.sv | 146 ++++++++++++++
 tb/tb_range_dma_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/range_dma_sequencer.sv
// Purpose : bus initiator copying each byte of the window [lower, upper) to one fixed target address.
// Latency : busy rises the cycle after an accepted start; N bytes take 2N+1 busy cycles with ready held high.
// Backpressure: I_ready low stalls READ/WRITE with all outputs held; I_start is ignored while busy.
//
// Ports:
//   I_clock, I_reset_n               clock (rising edge), async active-low reset
//   I_start, I_lower/I_upper/I_target start request and window/target, latched on acceptance
//   I_data, I_ready                  bus read data and cycle-complete handshake
//   O_address, O_data, O_read, O_write  bus request, all registered
//   O_busy, O_done, O_count          status: not-idle, one-cycle completion pulse, bytes written
// Build option: define RANGE_DMA_ABORT_EN to add the I_abort input (early termination).
module range_dma_sequencer #(
  parameter int P_width = 16,
  parameter int P_data  = 8
) (
  input  logic               I_clock,
  input  logic               I_reset_n,
  input  logic               I_start,
  input  logic [P_width-1:0] I_lower,
  input  logic [P_width-1:0] I_upper,
  input  logic [P_width-1:0] I_target,
  input  logic [P_data-1:0]  I_data,
  input  logic               I_ready,
`ifdef RANGE_DMA_ABORT_EN
  input  logic               I_abort,
`endif
  output logic [P_width-1:0] O_address,
  output logic [P_data-1:0]  O_data,
  output logic               O_read,
  output logic               O_write,
  output logic               O_busy,
  output logic               O_done,
  output logic [P_width-1:0] O_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [P_width-1:0] ONE = {{(P_width-1){1'b0}}, 1'b1};

  state_t             state;
  logic [P_width-1:0] cur_addr;
  logic [P_width-1:0] end_addr;
  logic [P_width-1:0] tgt_addr;
  logic [P_width-1:0] cur_next;
  logic               abort;

  // cur < end is guaranteed in READ/WRITE, so this increment never wraps.
  assign cur_next = cur_addr + ONE;

`ifdef RANGE_DMA_ABORT_EN
  assign abort = I_abort;
`else
  assign abort = 1'b0;
`endif

  // O_data doubles as the byte buffer: it is loaded on the read handshake
  // and presented unchanged throughout the following WRITE.
  always_ff @(posedge I_clock or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state     <= ST_IDLE;
      cur_addr  <= '0;
      end_addr  <= '0;
      tgt_addr  <= '0;
      O_address <= '0;
      O_data    <= '0;
      O_read    <= 1'b0;
      O_write   <= 1'b0;
      O_busy    <= 1'b0;
      O_done    <= 1'b0;
      O_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          O_done <= 1'b0;
          if (I_start) begin
            cur_addr <= I_lower;
            end_addr <= I_upper;
            tgt_addr <= I_target;
            O_count  <= '0;
            O_busy   <= 1'b1;
            if (I_lower < I_upper) begin
              state     <= ST_READ;
              O_address <= I_lower;
              O_read    <= 1'b1;
            end else begin
              // Empty window (including reversed bounds): no bus cycles.
              state  <= ST_DONE;
              O_done <= 1'b1;
            end
          end
        end

        ST_READ: begin
          if (abort) begin
            state  <= ST_DONE;
            O_read <= 1'b0;
            O_done <= 1'b1;
          end else if (I_ready) begin
            state     <= ST_WRITE;
            O_data    <= I_data;
            O_address <= tgt_addr;
            O_read    <= 1'b0;
            O_write   <= 1'b1;
          end
        end

        ST_WRITE: begin
          if (I_ready) begin
            // A completing write always counts, even when abort arrives with it.
            O_count  <= O_count + ONE;
            cur_addr <= cur_next;
            O_write  <= 1'b0;
            if (abort || (cur_next == end_addr)) begin
              state  <= ST_DONE;
              O_done <= 1'b1;
            end else begin
              state     <= ST_READ;
              O_address <= cur_next;
              O_read    <= 1'b1;
            end
          end else if (abort) begin
            state   <= ST_DONE;
            O_write <= 1'b0;
            O_done  <= 1'b1;
          end
        end

        ST_DONE: begin
          state  <= ST_IDLE;
          O_done <= 1'b0;
          O_busy <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_range_dma_sequencer.sv
// Purpose : randomized self-checking bench for range_dma_sequencer against a window-copy model.
// Latency : checks 2N+1 busy cycles with ready high and one done pulse per transfer.
// Backpressure: a bus responder inserts random or targeted wait states and drives junk data while not ready.
module tb_range_dma_sequencer;

  logic        I_clock = 1'b0;
  logic        I_reset_n = 1'b0;
  logic        I_start = 1'b0;
  logic [15:0] I_lower = '0;
  logic [15:0] I_upper = '0;
  logic [15:0] I_target = '0;
  logic [7:0]  I_data;
  logic        I_ready = 1'b1;
`ifdef RANGE_DMA_ABORT_EN
  logic        I_abort = 1'b0;
`endif
  logic [15:0] O_address;
  logic [7:0]  O_data;
  logic        O_read;
  logic        O_write;
  logic        O_busy;
  logic        O_done;
  logic [15:0] O_count;

  range_dma_sequencer #(.P_width(16), .P_data(8)) dut (
    .I_clock  (I_clock),
    .I_reset_n(I_reset_n),
    .I_start  (I_start),
    .I_lower  (I_lower),
    .I_upper  (I_upper),
    .I_target (I_target),
    .I_data   (I_data),
    .I_ready  (I_ready),
`ifdef RANGE_DMA_ABORT_EN
    .I_abort  (I_abort),
`endif
    .O_address(O_address),
    .O_data   (O_data),
    .O_read   (O_read),
    .O_write  (O_write),
    .O_busy   (O_busy),
    .O_done   (O_done),
    .O_count  (O_count)
  );

  always #5 I_clock = ~I_clock;

  // Source memory seen by the bus; junk is presented whenever ready is low.
  logic [7:0] mem [0:65535];
  logic [7:0] junk = 8'h5A;
  assign I_data = I_ready ? mem[O_address] : junk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Ready driver: 0 = always ready, 1 = random waits, 2 = 3 waits on the read of 0x0202.
  int rdy_mode = 0;
  int stall_left = 0;
  always @(posedge I_clock) begin
    #1;
    junk = 8'($urandom);
    case (rdy_mode)
      1: I_ready = ($urandom_range(0, 2) != 0);
      2: begin
        if (O_read && O_address == 16'h0202 && stall_left > 0) begin
          I_ready = 1'b0;
          stall_left--;
        end else begin
          I_ready = 1'b1;
        end
      end
      default: I_ready = 1'b1;
    endcase
  end

  // Bus monitor: records completed bus cycles and checks protocol invariants.
  logic [15:0] rd_q[$];
  logic [15:0] wr_a_q[$];
  logic [7:0]  wr_d_q[$];
  int busy_cycles = 0;
  int done_cnt = 0;
  bit          prev_valid = 0;
  bit          prev_ready, prev_rd, prev_wr;
  logic [15:0] prev_addr;
  logic [7:0]  prev_dat;

  always @(negedge I_clock) begin
    if (!I_reset_n) begin
      prev_valid = 0;
    end else begin
      if (O_read || O_write) check("rw_excl", {31'b0, O_read & O_write}, 32'd0);
      if (prev_valid && !prev_ready && (prev_rd || prev_wr)) begin
        check("hold_addr", O_address, prev_addr);
        check("hold_dat", O_data, prev_dat);
        check("hold_rd", O_read, prev_rd);
        check("hold_wr", O_write, prev_wr);
      end
      if (O_read && I_ready) rd_q.push_back(O_address);
      if (O_write && I_ready) begin
        wr_a_q.push_back(O_address);
        wr_d_q.push_back(O_data);
      end
      if (O_busy) busy_cycles++;
      if (O_done) done_cnt++;
      prev_valid = 1;
      prev_ready = I_ready;
      prev_rd    = O_read;
      prev_wr    = O_write;
      prev_addr  = O_address;
      prev_dat   = O_data;
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_addr"}, O_address, 32'd0);
    check({tag, "_data"}, O_data, 32'd0);
    check({tag, "_count"}, O_count, 32'd0);
    check({tag, "_rd"}, O_read, 32'd0);
    check({tag, "_wr"}, O_write, 32'd0);
    check({tag, "_busy"}, O_busy, 32'd0);
    check({tag, "_done"}, O_done, 32'd0);
  endtask

  // One transfer: expected bus trace is the window walked in order, each byte
  // copied to the target; empty windows produce no bus cycles.
  task automatic run_xfer(input logic [15:0] lo, input logic [15:0] up, input logic [15:0] tg,
                          input int mode, input bit inject);
    int n;
    int m;
    bit got;
    @(posedge I_clock); #1;
    rd_q.delete();
    wr_a_q.delete();
    wr_d_q.delete();
    busy_cycles = 0;
    done_cnt = 0;
    rdy_mode = mode;
    stall_left = 3;
    I_lower = lo;
    I_upper = up;
    I_target = tg;
    I_start = 1'b1;
    got = 0;
    for (int c = 0; c < 4000 && !got; c++) begin
      @(posedge I_clock); #1;
      if (inject && c == 3) begin
        I_start = 1'b1;
        I_lower = 16'h0500;
        I_upper = 16'h0510;
        I_target = 16'h3000;
      end else begin
        I_start = 1'b0;
        I_lower = 16'($urandom);
        I_upper = 16'($urandom);
        I_target = 16'($urandom);
      end
      if (O_done) got = 1;
    end
    I_start = 1'b0;
    check("done_seen", {31'b0, got}, 32'd1);
    @(posedge I_clock); #1;
    @(posedge I_clock); #1;
    n = (lo < up) ? (int'(up) - int'(lo)) : 0;
    check("rd_num", rd_q.size(), n);
    check("wr_num", wr_a_q.size(), n);
    m = (rd_q.size() < n) ? rd_q.size() : n;
    for (int i = 0; i < m; i++) check("rd_addr", rd_q[i], 32'(int'(lo) + i));
    m = (wr_a_q.size() < n) ? wr_a_q.size() : n;
    for (int i = 0; i < m; i++) begin
      check("wr_addr", wr_a_q[i], tg);
      check("wr_dat", wr_d_q[i], mem[16'(int'(lo) + i)]);
    end
    check("done_cnt", done_cnt, 32'd1);
    check("count", O_count, n);
    check("idle_busy", O_busy, 32'd0);
    if (mode == 0) check("busy_cyc", busy_cycles, 2 * n + 1);
  endtask

  task automatic reset_mid_transfer();
    bit hit;
    @(posedge I_clock); #1;
    rdy_mode = 0;
    I_lower = 16'h0200;
    I_upper = 16'h0204;
    I_target = 16'h2004;
    I_start = 1'b1;
    hit = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(posedge I_clock); #1;
      I_start = 1'b0;
      if (O_write && O_count == 16'd1) hit = 1;
    end
    check("rst_reach_wr1", {31'b0, hit}, 32'd1);
    #2;
    I_reset_n = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    @(posedge I_clock); #1;
    I_reset_n = 1'b1;
    @(posedge I_clock); #1;
    @(posedge I_clock); #1;
    check("rst_stay_idle", O_busy, 32'd0);
    check("rst_no_rd", O_read, 32'd0);
  endtask

`ifdef RANGE_DMA_ABORT_EN
  task automatic abort_test();
    bit hit;
    @(posedge I_clock); #1;
    rdy_mode = 0;
    done_cnt = 0;
    I_lower = 16'h0700;
    I_upper = 16'h0800;
    I_target = 16'h2000;
    I_start = 1'b1;
    hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge I_clock); #1;
      I_start = 1'b0;
      if (O_write && O_count == 16'd2) begin
        I_abort = 1'b1;
        hit = 1;
      end
    end
    check("abort_reach", {31'b0, hit}, 32'd1);
    @(posedge I_clock); #1;
    I_abort = 1'b0;
    check("abort_done", O_done, 32'd1);
    check("abort_count", O_count, 32'd3);
    @(posedge I_clock); #1;
    @(posedge I_clock); #1;
    check("abort_idle", O_busy, 32'd0);
    check("abort_done_cnt", done_cnt, 32'd1);
    check("abort_count_hold", O_count, 32'd3);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] lo;
    logic [15:0] up;
    int          len;
    int          mode;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0200] = 8'hA0;
    mem[16'h0201] = 8'hA1;
    mem[16'h0202] = 8'hA2;
    mem[16'h0203] = 8'hA3;

    repeat (3) @(posedge I_clock);
    #1;
    check_idle_outputs("reset");
    I_reset_n = 1'b1;

    reset_mid_transfer();
    run_xfer(16'h0200, 16'h0204, 16'h2004, 0, 0);   // basic copy
    run_xfer(16'h0200, 16'h0204, 16'h2004, 2, 0);   // wait states on 0x0202
    run_xfer(16'h0300, 16'h0300, 16'h2004, 0, 0);   // empty, equal bounds
    run_xfer(16'h0310, 16'h0300, 16'h2004, 0, 0);   // empty, reversed bounds
    run_xfer(16'hFF00, 16'h0000, 16'h2004, 0, 0);   // empty, no wrap
    run_xfer(16'h0200, 16'h0204, 16'h2004, 0, 1);   // start while busy ignored
    run_xfer(16'hFFFC, 16'hFFFF, 16'h0010, 1, 0);   // top of address space

    for (int t = 0; t < 10; t++) begin
      lo = 16'($urandom_range(16, 16'hFFF0));
      len = $urandom_range(0, 10);
      if ($urandom_range(0, 3) == 0) up = lo - 16'(len);
      else up = lo + 16'(len);
      mode = $urandom_range(0, 1);
      run_xfer(lo, up, 16'($urandom), mode, (lo < up) && (up - lo >= 3) && (mode == 0));
    end

`ifdef RANGE_DMA_ABORT_EN
    abort_test();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
